// File: rtl/rx_bit_assembler_if.sv
// rx_bit_assembler_if: NRZI-decoder-side inputs and byte/pulse outputs of the RX bit assembler
interface rx_bit_assembler_if;
  logic       rcving;
  logic       d_orig;
  logic       d_edge;
  logic [7:0] rx_byte;
  logic       byte_valid;
  logic       stuff_err;
  logic       bit_strobe;
  logic       sync_found;
  modport master (
    output rcving, d_orig, d_edge,
    input  rx_byte, byte_valid, stuff_err, bit_strobe, sync_found
  );
  modport slave (
    input  rcving, d_orig, d_edge,
    output rx_byte, byte_valid, stuff_err, bit_strobe, sync_found
  );
endinterface

// File: rtl/rx_bit_assembler.sv
// rx_bit_assembler: USB1.1 RX bit timing, unstuffing and LSB-first byte assembly; RX_SYNC_DETECT_EN adds SYNC hunt
module rx_bit_assembler #(
  parameter int OVS       = 8,
  parameter int SAMPLE_PT = 4,
  parameter int MAX_ONES  = 6
) (
  input logic clk,
  input logic rst,
  rx_bit_assembler_if.slave bus
);
  localparam int TW = $clog2(OVS);
  localparam int OW = $clog2(MAX_ONES + 1);
  localparam logic [TW-1:0] T_LAST = TW'(OVS - 1);
  localparam logic [TW-1:0] T_SMP  = TW'(SAMPLE_PT);
  localparam logic [OW-1:0] O_MAX  = OW'(MAX_ONES);
  logic [TW-1:0] timer;
  logic [OW-1:0] ones;
  logic [2:0]    bitcnt;
  logic [7:0]    shreg, rx_byte, sh_nxt;
  logic          byte_valid, stuff_err, sync_found;
  logic          strobe, stuffed, acc, serr, full, in_data, hunt_hit;
  always_comb begin
    strobe  = bus.rcving && !rst && timer == T_SMP && !bus.d_edge;
    stuffed = ones == O_MAX;
    acc     = strobe && !stuffed;
    serr    = strobe && stuffed && bus.d_orig;
    sh_nxt  = {bus.d_orig, shreg[7:1]};
    full    = acc && in_data && bitcnt == 3'd7;
  end
`ifdef RX_SYNC_DETECT_EN
  typedef enum logic {HUNT, DATA} state_t;
  state_t state, state_nxt;
  always_ff @(posedge clk) state <= rst ? HUNT : state_nxt;
  // bitcnt saturates at 7 while hunting, so a match needs at least 8 bits in the window
  always_comb begin
    state_nxt = state;
    in_data   = state == DATA;
    hunt_hit  = state == HUNT && acc && bitcnt == 3'd7 && sh_nxt == 8'h80;
    state_nxt = !bus.rcving ? HUNT : hunt_hit ? DATA : state;
  end
`else
  assign in_data  = 1'b1;
  assign hunt_hit = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      timer      <= '0;
      ones       <= '0;
      bitcnt     <= '0;
      shreg      <= '0;
      rx_byte    <= '0;
      byte_valid <= 1'b0;
      stuff_err  <= 1'b0;
      sync_found <= 1'b0;
    end else if (!bus.rcving) begin
      timer      <= '0;
      ones       <= '0;
      bitcnt     <= '0;
      byte_valid <= 1'b0;
      stuff_err  <= 1'b0;
      sync_found <= 1'b0;
    end else begin
      timer      <= (bus.d_edge || timer == T_LAST) ? '0 : timer + 1'b1;
      byte_valid <= full;
      stuff_err  <= serr;
      sync_found <= hunt_hit;
      if (strobe) ones <= (stuffed || !bus.d_orig) ? '0 : ones + 1'b1;
      if (acc) shreg <= sh_nxt;
      if (full) rx_byte <= sh_nxt;
      if (serr || hunt_hit) bitcnt <= '0;
      else if (acc) bitcnt <= (!in_data && bitcnt == 3'd7) ? bitcnt : bitcnt + 1'b1;
    end
  end
  assign bus.rx_byte    = rx_byte;
  assign bus.byte_valid = byte_valid;
  assign bus.stuff_err  = stuff_err;
  assign bus.bit_strobe = strobe;
  assign bus.sync_found = sync_found;
endmodule

// File: tb/tb_rx_bit_assembler.sv
// tb_rx_bit_assembler: directed frames with a byte scoreboard, stuffing, timing and sync checks
module tb_rx_bit_assembler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  rx_bit_assembler_if bus();
  rx_bit_assembler dut (.clk(clk), .rst(rst), .bus(bus));
  int checks = 0, errors = 0, cyc = 0;
  int strobe_cnt = 0, last_strobe = -100, serr_cnt = 0, serr_at = 0;
  int sync_cnt = 0, bv_cnt = 0, bv_at = 0;
  logic [7:0] exp_q[$];
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  always @(negedge clk) begin
    if (bus.bit_strobe === 1'b1) begin
      strobe_cnt++;
      last_strobe = cyc;
    end
    if (bus.stuff_err === 1'b1) begin
      serr_cnt++;
      serr_at = strobe_cnt;
      chk("stuff_err_latency", cyc - last_strobe, 1);
    end
    if (bus.sync_found === 1'b1) sync_cnt++;
    if (bus.byte_valid === 1'b1) begin
      bv_cnt++;
      bv_at = strobe_cnt;
      chk("byte_valid_latency", cyc - last_strobe, 1);
      chk("byte_expected", int'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) chk("rx_byte", int'(bus.rx_byte), int'(exp_q.pop_front()));
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send_bit(input logic b, input int len);
    for (int c = 0; c < len; c++) begin
      bus.d_orig = b;
      bus.d_edge = (c == 0) && !b;
      tick();
    end
  endtask
  task automatic send_byte(input logic [7:0] v, input bit alt);
    for (int i = 0; i < 8; i++) send_bit(v[i], alt ? ((i % 2 == 1) ? 9 : 7) : 8);
  endtask
  task automatic start_frame();
    strobe_cnt = 0;
    bv_cnt     = 0;
    serr_cnt   = 0;
    bus.rcving = 1'b1;
  endtask
  task automatic end_frame();
    bus.rcving = 1'b0;
    bus.d_orig = 1'b1;
    bus.d_edge = 1'b0;
    repeat (4) tick();
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    logic [7:0] v;
    bus.rcving = 1'b0;
    bus.d_orig = 1'b1;
    bus.d_edge = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_rx_byte", int'(bus.rx_byte), 0);
    chk("rst_byte_valid", int'(bus.byte_valid), 0);
    chk("rst_stuff_err", int'(bus.stuff_err), 0);
    chk("rst_bit_strobe", int'(bus.bit_strobe), 0);
    chk("rst_sync_found", int'(bus.sync_found), 0);
    rst = 1'b0;
    tick();
`ifdef RX_SYNC_DETECT_EN
    start_frame();
    exp_q.push_back(8'h3C);
    send_bit(1'b1, 8);
    send_bit(1'b0, 8);
    send_bit(1'b1, 8);
    send_byte(8'h80, 1'b0);
    send_byte(8'h3C, 1'b0);
    end_frame();
    chk("sync_found_count", sync_cnt, 1);
    chk("sync_byte_count", bv_cnt, 1);
    chk("sync_rx_byte_hold", int'(bus.rx_byte), 'h3C);
    chk("sync_stuff_err", serr_cnt, 0);
`else
    start_frame();
    exp_q.push_back(8'hA5);
    send_byte(8'hA5, 1'b0);
    end_frame();
    chk("a5_strobes", strobe_cnt, 8);
    chk("a5_byte_count", bv_cnt, 1);
    chk("a5_strobe_at_byte", bv_at, 8);
    chk("a5_rx_byte_hold", int'(bus.rx_byte), 'hA5);
    start_frame();
    send_bit(1'b1, 8);
    send_bit(1'b0, 8);
    send_bit(1'b1, 8);
    rst = 1'b1;
    bus.rcving = 1'b0;
    repeat (2) tick();
    chk("midrst_rx_byte", int'(bus.rx_byte), 0);
    chk("midrst_byte_valid", int'(bus.byte_valid), 0);
    chk("midrst_bit_strobe", int'(bus.bit_strobe), 0);
    rst = 1'b0;
    strobe_cnt = 0;
    repeat (20) tick();
    chk("midrst_no_strobes", strobe_cnt, 0);
    chk("midrst_no_bytes", bv_cnt, 0);
    start_frame();
    exp_q.push_back(8'hFF);
    repeat (6) send_bit(1'b1, 8);
    send_bit(1'b0, 8);
    repeat (2) send_bit(1'b1, 8);
    end_frame();
    chk("stuff_strobe_at_byte", bv_at, 9);
    chk("stuff_byte_count", bv_cnt, 1);
    chk("stuff_no_err", serr_cnt, 0);
    start_frame();
    exp_q.push_back(8'h3C);
    repeat (7) send_bit(1'b1, 8);
    chk("err_no_byte_yet", bv_cnt, 0);
    send_byte(8'h3C, 1'b0);
    end_frame();
    chk("err_count", serr_cnt, 1);
    chk("err_strobe_no", serr_at, 7);
    chk("err_byte_count", bv_cnt, 1);
    chk("err_strobes", strobe_cnt, 15);
    start_frame();
    exp_q.push_back(8'h5A);
    send_byte(8'h5A, 1'b1);
    end_frame();
    chk("alt_strobes", strobe_cnt, 8);
    chk("alt_byte_count", bv_cnt, 1);
    start_frame();
    v = 8'h15;
    for (int i = 0; i < 5; i++) send_bit(v[i], 8);
    end_frame();
    chk("drop_no_byte", bv_cnt, 0);
    chk("drop_rx_byte_hold", int'(bus.rx_byte), 'h5A);
    start_frame();
    exp_q.push_back(8'h12);
    send_byte(8'h12, 1'b0);
    end_frame();
    chk("refr_byte_count", bv_cnt, 1);
    chk("refr_rx_byte_hold", int'(bus.rx_byte), 'h12);
    chk("no_sync_found", sync_cnt, 0);
`endif
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
